// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ultrasonic ranger: periodic trigger, echo pulse width to cm
// using nested cycle counters, result held between measurements.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES   = 500,
  parameter int CYCLES_PER_CM = 2900,
  parameter int ECHO_TIMEOUT  = 1500000,
  parameter int MEAS_PERIOD   = 3000000,
  parameter int MAX_CM        = 500
) (
  input  logic        clock,
  input  logic        RESET,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [31:0] distance,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] SUB_LAST  = 32'(CYCLES_PER_CM - 1);
  localparam logic [31:0] TO_LAST   = 32'(ECHO_TIMEOUT - 1);
  localparam logic [31:0] PER_LAST  = 32'(MEAS_PERIOD - 1);
  localparam logic [31:0] CM_SAT    = 32'(MAX_CM);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t state, next_state;

  logic        echo_m, echo_s, echo_s_d;
  logic        rise, fall;
  logic [31:0] to_cnt, period_cnt, sub_cnt, cm_cnt;
  logic        trig_done, to_hit, period_done, count_en;

  function automatic logic [31:0] cm_sat_inc(input logic [31:0] cm);
    return (cm >= CM_SAT) ? CM_SAT : cm + 32'd1;
  endfunction

  assign rise        = echo_s & ~echo_s_d;
  assign fall        = ~echo_s & echo_s_d;
  assign trig_done   = (period_cnt == TRIG_LAST);
  assign to_hit      = (to_cnt == TO_LAST);
  assign period_done = (period_cnt == PER_LAST);
  // The rise cycle itself is a high cycle, so it is counted too.
  assign count_en    = ((state == WAIT_RISE) && rise) || ((state == MEASURE) && echo_s);

  always_ff @(posedge clock) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (enable) next_state = TRIG;
      TRIG:      if (trig_done) next_state = WAIT_RISE;
      WAIT_RISE: begin
        if (to_hit)    next_state = HOLDOFF;
        else if (rise) next_state = MEASURE;
      end
      MEASURE:   if (to_hit || fall) next_state = HOLDOFF;
      HOLDOFF:   if (period_done) next_state = enable ? TRIG : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    trig = (state == TRIG);
    busy = (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!RESET) begin
      echo_m     <= 1'b0;
      echo_s     <= 1'b0;
      echo_s_d   <= 1'b0;
      period_cnt <= '0;
      to_cnt     <= '0;
      sub_cnt    <= '0;
      cm_cnt     <= '0;
      distance   <= CM_SAT;
      timeout    <= 1'b0;
      valid      <= 1'b0;
    end else begin
      echo_m   <= echo;
      echo_s   <= echo_m;
      echo_s_d <= echo_s;
      valid    <= 1'b0;

      // Period counter starts at 0 on the first TRIG cycle of every measurement.
      if ((state == IDLE) || ((state == HOLDOFF) && period_done))
        period_cnt <= '0;
      else if (!period_done)
        period_cnt <= period_cnt + 32'd1;

      if (state == TRIG) begin
        to_cnt  <= '0;
        sub_cnt <= '0;
        cm_cnt  <= '0;
      end else if ((state == WAIT_RISE) || (state == MEASURE)) begin
        to_cnt <= to_cnt + 32'd1;
        if (count_en) begin
          if (sub_cnt == SUB_LAST) begin
            sub_cnt <= '0;
            cm_cnt  <= cm_sat_inc(cm_cnt);
          end else begin
            sub_cnt <= sub_cnt + 32'd1;
          end
        end
      end

      // Timeout takes priority over a simultaneous falling edge.
      if (((state == WAIT_RISE) || (state == MEASURE)) && to_hit) begin
        distance <= CM_SAT;
        timeout  <= 1'b1;
        valid    <= 1'b1;
      end else if ((state == MEASURE) && fall) begin
        distance <= cm_cnt;
        timeout  <= 1'b0;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
Drives an HC-SR04-style ultrasonic sensor and converts each echo pulse into a distance in cm. Its 32-bit distance output feeds the proximity buzzer/LED stage. The block measures periodically while enabled and keeps the last result stable between measurements. Distance is produced by nested cycle counters; no divider is used.

Parameters:
TRIG_CYCLES, 500, width of the trigger pulse in clock cycles (10 us at 50 MHz)
CYCLES_PER_CM, 2900, echo-high clock cycles per cm (58 us at 50 MHz)
ECHO_TIMEOUT, 1500000, maximum cycles from TRIG end to echo fall before the measurement is abandoned (30 ms)
MEAS_PERIOD, 3000000, minimum cycles between successive trigger rising edges (60 ms)
MAX_CM, 500, saturation value and value reported on timeout or after reset

Ports:
clock  input  1  system clock
RESET  input  1  synchronous, active-low reset
enable  input  1  1 = measure continuously; 0 = stop after the current cycle
echo  input  1  sensor echo pin, asynchronous
trig  output  1  sensor trigger pin
distance  output  32  last measured distance in cm, held between updates
valid  output  1  one-cycle pulse when distance is updated, including on timeout
timeout  output  1  1 = last measurement timed out; updated together with valid
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset: RESET is synchronous and active-low; the clock is clock. While RESET=0 on a clock edge:
  - state=IDLE, trig=0, distance=MAX_CM, valid=0, timeout=0, busy=0.
  - All counters and both echo synchronizer flops clear to 0.
  - Reset mid-measurement aborts immediately; trig drops on the next edge.
- Echo input: 2-flop synchronizer to echo_s (2-cycle latency), plus a registered echo_s_d for edge detection.
  - rise = echo_s & ~echo_s_d; fall = ~echo_s & echo_s_d.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
  - IDLE: if enable=1, go to TRIG next cycle and clear period_cnt.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE. Clear to_cnt, cm_cnt and sub_cnt on exit.
  - WAIT_RISE: to_cnt increments each cycle.
    - Only a rise edge advances to MEASURE. An echo already high on entry is ignored until it falls and rises again.
    - If to_cnt reaches ECHO_TIMEOUT-1 first: distance=MAX_CM, timeout=1, valid pulse, then HOLDOFF.
  - MEASURE: to_cnt keeps counting. Each cycle with echo_s=1:
    - sub_cnt increments.
    - When sub_cnt reaches CYCLES_PER_CM-1, sub_cnt wraps to 0 and cm_cnt increments, saturating at MAX_CM.
  - MEASURE exit on fall: distance=cm_cnt, i.e. floor(high_cycles/CYCLES_PER_CM) capped at MAX_CM. Also timeout=0, valid pulse, then HOLDOFF.
  - MEASURE exit on timeout: to_cnt reaching ECHO_TIMEOUT-1 is handled exactly as in WAIT_RISE. Timeout wins if fall and timeout occur in the same cycle.
  - HOLDOFF: wait until period_cnt reaches MEAS_PERIOD-1, counting from the first TRIG cycle. Then go to TRIG if enable=1, else IDLE.
- period_cnt runs in every non-IDLE state and saturates at MEAS_PERIOD-1. Successive trig rising edges are therefore exactly MEAS_PERIOD cycles apart.
- Enable: sampled only in IDLE and at HOLDOFF exit. Deasserting enable mid-measurement lets the current measurement complete.
- valid: high for exactly one cycle per measurement, on the cycle after the fall/timeout detection edge (registered). distance and timeout change only on that same edge.
- Counter widths: 32 bits for to_cnt and period_cnt; 32 bits for sub_cnt and cm_cnt. distance is zero-extended to 32 bits.

Test Plan:
(Bench parameters: TRIG_CYCLES=5, CYCLES_PER_CM=4, ECHO_TIMEOUT=400, MEAS_PERIOD=600, MAX_CM=50.)
- Reset then idle: RESET=0 for 3 cycles, enable=0 -> trig=0, distance=50, valid=0, timeout=0, busy=0; stays so for 1000 cycles.
- Basic range: enable=1; echo high 40 cycles starting 20 cycles after trig falls -> trig high exactly 5 cycles; one valid pulse; distance=10; timeout=0. Repeat with echo high 43 -> distance=10 (floor).
- Saturation: echo high 300 cycles -> distance=50, timeout=0.
- Timeout, no echo: echo held low -> valid 400 cycles after TRIG end; distance=50, timeout=1.
- Timeout, stuck echo: echo held high from before TRIG -> valid 400 cycles after TRIG end; distance=50, timeout=1.
- Period, enable drop, reset abort: enable=1 continuously -> trig rising edges exactly 600 cycles apart. Drop enable mid-MEASURE -> that measurement still produces valid, then IDLE with no further trig. Assert RESET=0 during TRIG -> trig=0 and busy=0 on the next edge; distance returns to 50.
